// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace stepper.
// Holds the run-controller state encoding and the mode codes accepted with start.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous trace FIFO with a registered read port and occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module wb_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage carries no reset so it maps onto block RAM; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= pop_ok;
      if (pop_ok) begin
        rdata_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign level  = level_reg;

endmodule

// File: rtl/wb_trace_stepper.sv
// Run controller gating the pipeline clock-enable (free-run, single-step, N-cycle burst)
// and capturing valid writeback values into a trace FIFO while enabled.
module wb_trace_stepper
  import wb_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     start,
  input  logic                     stop,
  input  logic [CNT_W-1:0]         burst_len,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_valid,
  output logic                     pipe_en,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         cycles,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  state_t            state_reg, state_next;
  logic              pipe_en_reg, pipe_en_next;
  logic              done_reg, done_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [CNT_W-1:0]  cycles_reg;
  logic              overflow_reg;
  logic              start_ok;
  logic              capture;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign start_ok = (state_reg == IDLE) && start && (mode != MODE_IDLE);

  // remaining counts enabled cycles still owed after the one being issued now.
  always_comb begin
    state_next     = state_reg;
    pipe_en_next   = 1'b0;
    done_next      = 1'b0;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (mode)
            MODE_RUN: begin
              state_next   = RUN;
              pipe_en_next = 1'b1;
            end
            MODE_STEP: begin
              state_next   = STEP;
              pipe_en_next = 1'b1;
            end
            MODE_BURST: begin
              state_next = BURST;
              if (burst_len != '0) begin
                pipe_en_next   = 1'b1;
                remaining_next = burst_len - CNT_W'(1);
              end else begin
                remaining_next = '0;
              end
            end
            default: state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          pipe_en_next = 1'b1;
        end
      end
      STEP: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      BURST: begin
        if (stop || remaining_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          pipe_en_next   = 1'b1;
          remaining_next = remaining_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pipe_en_reg   <= 1'b0;
      done_reg      <= 1'b0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pipe_en_reg   <= pipe_en_next;
      done_reg      <= done_next;
      remaining_reg <= remaining_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycles_reg <= '0;
    end else if (start_ok) begin
      cycles_reg <= '0;
    end else if (pipe_en_reg && cycles_reg != '1) begin
      cycles_reg <= cycles_reg + CNT_W'(1);
    end
  end

  assign capture = pipe_en_reg && wb_valid;
  // A pop on the same edge makes room, so only a full FIFO without a real pop drops.
  assign drop    = capture && fifo_full && !(rd_en && !fifo_empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  wb_trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (capture),
    .wdata  (wb_data),
    .pop    (rd_en),
    .rdata  (rd_data),
    .rvalid (rd_valid),
    .level  (level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pipe_en  = pipe_en_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign cycles   = cycles_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_wb_trace_stepper.sv
// Directed bench for wb_trace_stepper: a run-schedule/queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_wb_trace_stepper;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  burst_len;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              pipe_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cycles;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              clr_ovf;

  wb_trace_stepper #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .wb_data   (wb_data),
    .wb_valid  (wb_valid),
    .pipe_en   (pipe_en),
    .busy      (busy),
    .done      (done),
    .cycles    (cycles),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run owes a number of enabled cycles (-1 = unbounded);
  // the trace buffer is a plain queue bounded at DEPTH.
  logic [DATA_W-1:0] m_q[$];
  bit                m_busy, m_pipe_en, m_done, m_ovf, m_rd_valid;
  int                m_left;
  logic [1:0]        m_kind;
  logic [CNT_W-1:0]  m_cycles;
  logic [DATA_W-1:0] m_rd_data;

  task automatic model_emit();
    if (m_left != 0) begin
      m_pipe_en = 1;
      if (m_left > 0) m_left--;
    end else begin
      m_pipe_en = 0;
    end
  endtask

  task automatic model_step();
    bit did_pop, did_drop, started;
    if (!rst_n) begin
      m_q.delete();
      m_busy = 0; m_pipe_en = 0; m_done = 0; m_ovf = 0; m_rd_valid = 0;
      m_left = 0; m_kind = 2'd0; m_cycles = '0; m_rd_data = '0;
    end else begin
      did_pop  = rd_en && (m_q.size() > 0);
      did_drop = 0;
      if (did_pop) m_rd_data = m_q.pop_front();
      m_rd_valid = did_pop;
      if (m_pipe_en && wb_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(wb_data);
        else did_drop = 1;
      end
      if (did_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      started = !m_busy && start && (mode != 2'd0);
      if (started) m_cycles = '0;
      else if (m_pipe_en && m_cycles != {CNT_W{1'b1}}) m_cycles = m_cycles + 1'b1;
      m_done = 0;
      if (started) begin
        m_busy = 1;
        m_kind = mode;
        m_left = (mode == 2'd1) ? -1 : (mode == 2'd2) ? 1 : int'(burst_len);
        model_emit();
      end else if (m_busy) begin
        if ((stop && m_kind != 2'd2) || m_left == 0) begin
          m_busy = 0; m_pipe_en = 0; m_done = 1;
        end else begin
          model_emit();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("pipe_en", pipe_en, m_pipe_en);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cycles", cycles, m_cycles);
      chk("level", level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("rd_valid", rd_valid, m_rd_valid);
      chk("rd_data", rd_data, m_rd_data);
    end
  end

  // Stimulus clock step: acts like the pipeline, presenting a fresh word per enabled cycle.
  int                en_cnt, done_cnt;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] got_q[$];

  task automatic cyc();
    @(negedge clk);
    if (pipe_en) begin
      en_cnt++;
      wb_data   = data_next;
      data_next = data_next + 1;
    end
    if (done) done_cnt++;
    if (rd_valid) got_q.push_back(rd_data);
  endtask

  task automatic launch(input logic [1:0] m, input logic [CNT_W-1:0] n);
    en_cnt = 0; done_cnt = 0;
    mode = m; burst_len = n; start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    rst_n = 0; mode = 0; start = 0; stop = 0; burst_len = '0;
    wb_data = '0; wb_valid = 1; rd_en = 0; clr_ovf = 0;
    data_next = 32'h10;
    @(posedge clk);
    chk_on = 1;
    cyc(); cyc();
    chk("reset pipe_en", pipe_en, 1'b0);
    chk("reset level", level, 0);
    rst_n = 1;
    cyc();

    // Burst of 5 with incrementing data
    launch(2'd3, 16'd5);
    repeat (8) cyc();
    chk("burst5 enabled cycles", en_cnt, 5);
    chk("burst5 done pulses", done_cnt, 1);
    chk("burst5 level", level, 5);
    chk("burst5 cycles", cycles, 5);
    got_q.delete();
    rd_en = 1;
    repeat (5) cyc();
    rd_en = 0;
    cyc();
    chk("burst5 pop count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk("burst5 pop data", got_q[i], 32'h10 + i);

    // Single step
    launch(2'd2, 16'd0);
    repeat (3) cyc();
    chk("step enabled cycles", en_cnt, 1);
    chk("step done pulses", done_cnt, 1);
    chk("step cycles", cycles, 1);
    rd_en = 1; cyc(); rd_en = 0; cyc();

    // Free-run for 20 cycles with no reads: FIFO fills, overflow sets
    data_next = 32'h100;
    launch(2'd1, 16'd0);
    repeat (19) cyc();
    stop = 1; cyc(); stop = 0;
    repeat (2) cyc();
    chk("run level full", level, 16);
    chk("run overflow", overflow, 1'b1);
    chk("run cycles", cycles, 20);
    got_q.delete();
    rd_en = 1; cyc(); rd_en = 0; cyc();
    chk("run first pop", (got_q.size() > 0) ? got_q[0] : 32'hdead, 32'h100);
    clr_ovf = 1; cyc(); clr_ovf = 0; cyc();
    chk("clr_ovf clears", overflow, 1'b0);

    // Refill to full, then push and pop on the same edge
    launch(2'd2, 16'd0);
    repeat (3) cyc();
    chk("refill level", level, 16);
    got_q.delete();
    launch(2'd2, 16'd0);
    rd_en = 1; cyc(); rd_en = 0;
    repeat (2) cyc();
    chk("full push+pop level", level, 16);
    chk("full push+pop overflow", overflow, 1'b0);
    chk("full push+pop data", (got_q.size() > 0) ? got_q[0] : 32'hdead, 32'h101);
    rd_en = 1; repeat (18) cyc(); rd_en = 0; cyc();
    chk("drained level", level, 0);

    // Zero-length burst
    launch(2'd3, 16'd0);
    repeat (4) cyc();
    chk("burst0 enabled cycles", en_cnt, 0);
    chk("burst0 done pulses", done_cnt, 1);
    chk("burst0 cycles", cycles, 0);

    // Reset in the middle of a burst of 10
    launch(2'd3, 16'd10);
    repeat (4) cyc();
    rst_n = 0; cyc();
    chk("midreset pipe_en", pipe_en, 1'b0);
    chk("midreset level", level, 0);
    chk("midreset busy", busy, 1'b0);
    rst_n = 1; cyc();
    launch(2'd3, 16'd3);
    repeat (6) cyc();
    chk("post-reset burst enabled", en_cnt, 3);
    chk("post-reset level", level, 3);
    chk("post-reset done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_stepper.md
# wb_trace_stepper

Parametrised run controller and writeback trace buffer for the `pipeline` core. It gates the pipeline through a clock-enable in one of three modes: free-run, single-step or N-cycle burst. While the pipeline is enabled, it captures each valid writeback-mux value into a FIFO that a host or bench drains at its own rate. It sits between the top-level clock and the `pipeline` instance, beside the `outMuxWb` path.

## Interface
- DATA_W, 32, width of the writeback word captured
- DEPTH, 16, trace FIFO entries; power of two, at least 2
- CNT_W, 16, width of the burst length and cycle counter
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- mode  in  2  0 idle, 1 free-run, 2 step, 3 burst; sampled only when a start is accepted
- start  in  1  one-cycle request to begin the selected mode
- stop  in  1  abort a free-run or burst
- burst_len  in  CNT_W  enabled cycles for burst mode; sampled with start
- wb_data  in  DATA_W  writeback-mux value from the pipeline
- wb_valid  in  1  wb_data is meaningful this cycle
- pipe_en  out  1  registered clock-enable to the pipeline
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle pulse when a run ends
- cycles  out  CNT_W  enabled cycles since the last accepted start; saturating
- rd_en  in  1  pop request
- rd_data  out  DATA_W  popped word, registered
- rd_valid  out  1  rd_data is valid this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; a capture was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

## Operation
- States: IDLE, RUN, STEP, BURST.
- IDLE:
  - start with mode 1 goes to RUN.
  - start with mode 2 goes to STEP.
  - start with mode 3 goes to BURST and loads remaining = burst_len.
  - start with mode 0 is ignored.
  - An accepted start clears cycles.
- RUN: pipe_en = 1 every cycle until stop. On stop, go to IDLE and pulse done.
- STEP: pipe_en = 1 for exactly one cycle, then go to IDLE and pulse done.
- BURST:
  - pipe_en = 1 while remaining > 0; remaining decrements each enabled cycle.
  - When remaining reaches 0, go to IDLE and pulse done.
  - stop aborts early and pulses done.
- burst_len = 0: no enabled cycle. Go IDLE → BURST → IDLE with done on the second cycle after start, and pipe_en never rises.
- start while busy is ignored. stop in IDLE or STEP is ignored.
- cycles increments on each pipe_en = 1 cycle and saturates at 2^CNT_W − 1.
- Capture: push wb_data when pipe_en = 1 and wb_valid = 1 in the same cycle.
- Full FIFO:
  - A push is dropped and overflow sets.
  - If rd_en pops on that same cycle, the push succeeds instead and overflow does not set.
- Empty FIFO: rd_en is ignored and rd_valid = 0.
- Ordering is strictly FIFO. Pointers wrap modulo DEPTH.
- clr_ovf clears overflow. If a drop happens on the same cycle, set wins.

## Timing
- Reset values:
  - state IDLE; pipe_en, busy, done, rd_valid and overflow 0.
  - cycles 0, level 0, rd_data 0, FIFO pointers 0.
- Reset mid-run: pipe_en is 0 on the cycle after the reset edge. FIFO contents are discarded.
- start accepted on edge k: busy = 1 and pipe_en = 1 from edge k+1.
- A burst of N keeps pipe_en high for edges k+1 … k+N. done and busy = 0 come at edge k+N+1.
- stop sampled on edge k: pipe_en = 0 and done = 1 from edge k+1.
- Read latency is 1. rd_en at edge k gives rd_data and rd_valid at edge k+1.
- level updates on the edge following a push or pop. A simultaneous push and pop leaves level unchanged.

## Structure
- Package wb_trace_pkg holds:
  - the state enum (IDLE, RUN, STEP, BURST);
  - mode constants MODE_IDLE, MODE_RUN, MODE_STEP, MODE_BURST.
- Sub-module wb_trace_fifo: a synchronous DEPTH×DATA_W FIFO with a registered read port, level, and full/empty outputs.
- The top level holds the FSM, the burst and cycle counters, and the overflow flag.

## Test plan
- Reset, then start with mode 3 and burst_len = 5, wb_valid = 1 and wb_data incrementing from 0x10: exactly 5 pipe_en cycles, done one cycle later, level = 5, pops return 0x10…0x14.
- Start with mode 2: one pipe_en pulse, done on the next edge, cycles = 1.
- Start with mode 1, stop after 20 cycles, DEPTH = 16, no reads: level = 16, overflow = 1, first pop = first captured word. clr_ovf then clears overflow.
- With the FIFO full, a push and pop on the same cycle: push accepted, overflow stays 0, level stays 16.
- Start with mode 3 and burst_len = 0: pipe_en never rises, done asserts, cycles = 0.
- Assert rst_n = 0 in the middle of a burst of 10: pipe_en = 0 and level = 0 on the next edge. A following start then behaves as after power-up.
